// File: rtl/sa_cache_pkg.sv
// Shared widths, FSM encoding and age-vector type for the 4-way set-associative cache.
package sa_cache_pkg;
  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 6;
  localparam int DATA_W   = 32;
  localparam int WAYS     = 4;
  localparam int SETS     = 1 << INDEX_W;
  localparam int AGE_W    = 2;
  localparam int WAY_W    = 2;

  typedef enum logic {IDLE = 1'b0, MISS_WAIT = 1'b1} state_t;
  typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

  // way w starts with age w
  localparam age_vec_t AGE_RST = {2'd3, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/sa_cache_lru.sv
// Per-set age-based LRU: next ages for an access to acc_way, plus the replacement victim.
module sa_cache_lru
  import sa_cache_pkg::*;
(
  input  age_vec_t         age,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] acc_way,
  output age_vec_t         next_age,
  output logic [WAY_W-1:0] victim
);
  always_comb begin
    next_age = age;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        next_age[w] = '0;
      else if (age[w] < age[acc_way])
        next_age[w] = age[w] + AGE_W'(1);
    end
  end

  // Oldest way by default; the descending scan lets the lowest invalid way win.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w]) victim = WAY_W'(w);
  end
endmodule

// File: rtl/sa_cache_4way.sv
// 4-way set-associative write-back / write-allocate cache, one word per line,
// stalling on cache_miss until the memory refill arrives.
module sa_cache_4way
  import sa_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [DATA_W-1:0]   dataW,
  input  logic                memRW,
  input  logic [DATA_W-1:0]   i_memory_line,
  input  logic                i_memory_response,
  output logic [DATA_W-1:0]   o_data,
  output logic [DATA_W-1:0]   line_data,
  output logic                cache_miss,
  output logic [DATA_W-1:0]   o_evict_data,
  output logic [DATA_W-1:0]   o_evict_addr,
  output logic                o_evict
);
  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [DATA_W-1:0] data_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  age_vec_t          age_mem   [SETS];

  state_t            state, state_nxt;
  logic [WAY_W-1:0]  victim_r, hit_way, acc_way, lru_victim;
  logic [WAYS-1:0]   hit_vec, set_valid;
  logic              hit, fill, wr_hit, lru_upd, miss_det, evict_now;
  age_vec_t          next_age;
  logic              unused_offset;

  assign unused_offset = ^i_offset;
  assign set_valid     = valid_mem[i_index];

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = set_valid[w] && (tag_mem[w][i_index] == i_tag);
  end

  assign hit = |hit_vec;
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  sa_cache_lru u_lru (
    .age      (age_mem[i_index]),
    .valid    (set_valid),
    .acc_way  (acc_way),
    .next_age (next_age),
    .victim   (lru_victim)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!hit) state_nxt = MISS_WAIT;
      MISS_WAIT: if (i_memory_response) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_way   = (state == MISS_WAIT) ? victim_r : hit_way;
    fill      = (state == MISS_WAIT) && i_memory_response;
    wr_hit    = (state == IDLE) && hit && memRW;
    miss_det  = (state == IDLE) && !hit;
    lru_upd   = ((state == IDLE) && hit) || fill;
    evict_now = miss_det && set_valid[lru_victim] && dirty_mem[i_index][lru_victim];
  end

  // Tag/data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_hit) data_mem[hit_way][i_index] <= dataW;
    if (fill) begin
      tag_mem[victim_r][i_index]  <= i_tag;
      data_mem[victim_r][i_index] <= memRW ? dataW : i_memory_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        age_mem[s]   <= AGE_RST;
      end
    end else begin
      if (lru_upd) age_mem[i_index] <= next_age;
      if (wr_hit)  dirty_mem[i_index][hit_way] <= 1'b1;
      if (fill) begin
        valid_mem[i_index][victim_r] <= 1'b1;
        dirty_mem[i_index][victim_r] <= memRW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data       <= '0;
      line_data    <= '0;
      cache_miss   <= 1'b0;
      o_evict      <= 1'b0;
      o_evict_data <= '0;
      o_evict_addr <= '0;
      victim_r     <= '0;
    end else begin
      o_evict <= 1'b0;
      if (state == IDLE) begin
        if (hit) begin
          cache_miss <= 1'b0;
          line_data  <= memRW ? dataW : data_mem[hit_way][i_index];
          if (!memRW) o_data <= data_mem[hit_way][i_index];
        end else begin
          cache_miss <= 1'b1;
          victim_r   <= lru_victim;
          if (evict_now) begin
            o_evict      <= 1'b1;
            o_evict_data <= data_mem[lru_victim][i_index];
            o_evict_addr <= {tag_mem[lru_victim][i_index], i_index, OFFSET_W'(0)};
          end
        end
      end else if (fill) begin
        cache_miss <= 1'b0;
        line_data  <= memRW ? dataW : i_memory_line;
        if (!memRW) o_data <= i_memory_line;
      end
    end
  end
endmodule

// File: tb/tb_sa_cache_4way.sv
// Scoreboard bench for sa_cache_4way: expectations queued at drive time, checked after the edge.
module tb_sa_cache_4way;
  import sa_cache_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [TAG_W-1:0]    i_tag;
  logic [INDEX_W-1:0]  i_index;
  logic [OFFSET_W-1:0] i_offset;
  logic [DATA_W-1:0]   dataW, i_memory_line;
  logic                memRW, i_memory_response;
  logic [DATA_W-1:0]   o_data, line_data, o_evict_data, o_evict_addr;
  logic                cache_miss, o_evict;

  sa_cache_4way dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
    .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
    .cache_miss(cache_miss), .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr),
    .o_evict(o_evict)
  );

  always #5 clk = ~clk;

  localparam int S_ODATA = 0, S_LINE = 1, S_MISS = 2, S_EVICT = 3, S_EDATA = 4, S_EADDR = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_ODATA: return o_data;
      S_LINE:  return line_data;
      S_MISS:  return {31'd0, cache_miss};
      S_EVICT: return {31'd0, o_evict};
      S_EDATA: return o_evict_data;
      default: return o_evict_addr;
    endcase
  endfunction

  task automatic exp_out(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, probe(e.sel), e.exp);
    end
  endtask

  task automatic access(input logic [17:0] t, input logic [7:0] idx, input logic rw,
                        input logic [31:0] wd);
    @(negedge clk);
    i_tag = t; i_index = idx; memRW = rw; dataW = wd;
    i_offset = 6'h2a; i_memory_response = 1'b0;
  endtask

  task automatic respond(input logic [31:0] line);
    @(negedge clk);
    i_memory_response = 1'b1; i_memory_line = line;
  endtask

  logic [31:0] exp_addr;

  initial begin
    rst = 1'b1;
    i_tag = '0; i_index = '0; i_offset = '0; dataW = '0; memRW = 1'b0;
    i_memory_line = '0; i_memory_response = 1'b0;
    #12;
    chk("rst_odata", o_data, 32'h0);
    chk("rst_miss", {31'd0, cache_miss}, 32'h0);
    chk("rst_evict", {31'd0, o_evict}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // cold read miss then refill
    access(18'h1, 8'h05, 1'b0, 32'h0);
    exp_out("t1_miss", S_MISS, 1); exp_out("t1_noevict", S_EVICT, 0); step();
    respond(32'hDEADBEEF);
    exp_out("t1_fill", S_ODATA, 32'hDEADBEEF); exp_out("t1_line", S_LINE, 32'hDEADBEEF);
    exp_out("t1_done", S_MISS, 0); step();

    // re-read hits
    access(18'h1, 8'h05, 1'b0, 32'h0);
    exp_out("t2_hit", S_ODATA, 32'hDEADBEEF); exp_out("t2_nomiss", S_MISS, 0); step();

    // write hit: o_data holds, line_data shows new word
    access(18'h1, 8'h05, 1'b1, 32'h12345678);
    exp_out("t3_line", S_LINE, 32'h12345678); exp_out("t3_ohold", S_ODATA, 32'hDEADBEEF);
    exp_out("t3_nomiss", S_MISS, 0); step();
    access(18'h1, 8'h05, 1'b0, 32'h0);
    exp_out("t3_rdback", S_ODATA, 32'h12345678); step();

    // fill the remaining ways of set 5
    for (int t = 2; t <= 4; t++) begin
      access(18'(t), 8'h05, 1'b0, 32'h0);
      exp_out("t4_fillmiss", S_MISS, 1); exp_out("t4_fillclean", S_EVICT, 0); step();
      respond(32'hA0000000 | t);
      exp_out("t4_filldata", S_ODATA, 32'hA0000000 | t); step();
    end

    // tag 5 evicts dirty tag 1 (oldest)
    exp_addr = {18'h1, 8'h05, 6'h0};
    access(18'h5, 8'h05, 1'b0, 32'h0);
    exp_out("t4_miss", S_MISS, 1); exp_out("t4_evict", S_EVICT, 1);
    exp_out("t4_edata", S_EDATA, 32'h12345678); exp_out("t4_eaddr", S_EADDR, exp_addr); step();
    access(18'h5, 8'h05, 1'b0, 32'h0);
    exp_out("t4_pulse1", S_EVICT, 0); exp_out("t4_wait", S_MISS, 1); step();
    respond(32'hA0000005);
    exp_out("t4_refill", S_ODATA, 32'hA0000005); exp_out("t4_done", S_MISS, 0); step();
    access(18'h5, 8'h05, 1'b0, 32'h0);
    exp_out("t4_rehit", S_ODATA, 32'hA0000005); exp_out("t4_rehit_m", S_MISS, 0); step();

    // clean victim (tag 2), three wait cycles
    access(18'h6, 8'h05, 1'b0, 32'h0);
    exp_out("t5_miss", S_MISS, 1); exp_out("t5_noevict", S_EVICT, 0); step();
    for (int i = 0; i < 3; i++) begin
      access(18'h6, 8'h05, 1'b0, 32'h0);
      exp_out("t5_wait", S_MISS, 1); exp_out("t5_wait_ev", S_EVICT, 0);
      exp_out("t5_ohold", S_ODATA, 32'hA0000005); step();
    end
    respond(32'hA0000006);
    exp_out("t5_fill", S_ODATA, 32'hA0000006); exp_out("t5_done", S_MISS, 0); step();

    // response while IDLE is ignored; hit returns stored word
    @(negedge clk);
    i_memory_response = 1'b1; i_memory_line = 32'h0BAD0BAD;
    exp_out("idle_resp", S_ODATA, 32'hA0000006); exp_out("idle_resp_m", S_MISS, 0); step();

    // write miss allocates dataW, o_data unchanged
    access(18'h7, 8'h09, 1'b1, 32'h55AA55AA);
    exp_out("wm_miss", S_MISS, 1); exp_out("wm_noevict", S_EVICT, 0); step();
    respond(32'hFFFF0000);
    exp_out("wm_line", S_LINE, 32'h55AA55AA); exp_out("wm_ohold", S_ODATA, 32'hA0000006);
    exp_out("wm_done", S_MISS, 0); step();
    access(18'h7, 8'h09, 1'b0, 32'h0);
    exp_out("wm_rdback", S_ODATA, 32'h55AA55AA); step();

    // reset while waiting on a miss
    access(18'h8, 8'h05, 1'b0, 32'h0);
    exp_out("t6_miss", S_MISS, 1); step();
    rst = 1'b1;
    #1;
    chk("t6_rst_miss", {31'd0, cache_miss}, 32'h0);
    chk("t6_rst_odata", o_data, 32'h0);
    chk("t6_rst_line", line_data, 32'h0);
    chk("t6_rst_evict", {31'd0, o_evict}, 32'h0);
    chk("t6_rst_edata", o_evict_data, 32'h0);
    chk("t6_rst_eaddr", o_evict_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(18'h6, 8'h05, 1'b0, 32'h0);
    exp_out("t6_inval6", S_MISS, 1); exp_out("t6_noevict", S_EVICT, 0); step();
    respond(32'hA0000066);
    exp_out("t6_fill6", S_ODATA, 32'hA0000066); step();
    access(18'h1, 8'h05, 1'b0, 32'h0);
    exp_out("t6_inval1", S_MISS, 1); step();
    respond(32'hA0000011);
    exp_out("t6_fill1", S_ODATA, 32'hA0000011); exp_out("t6_done", S_MISS, 0); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
